// File: rtl/dsp_reset_responder.sv
// Card-side responder for the host DSP reset handshake: decodes the reset,
// buffer-status and read-data ports and sequences hold, init delay and ready byte.
module dsp_reset_responder #(
   parameter logic [15:0] BASE_ADDRESS = 16'h0000,
   parameter int unsigned MIN_HOLD     = 24,
   parameter int unsigned READY_DELAY  = 16,
   parameter int unsigned CNT_WIDTH    = 6
) (
   input  logic        bus_clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [15:0] data_in,
   input  logic        write_strobe,
   input  logic        read_strobe,
   output logic [15:0] data_out,
   output logic        data_oe,
   output logic        in_reset,
   output logic        dsp_ready
);

   localparam logic [15:0] ADDR_RST  = BASE_ADDRESS + 16'h0006;
   localparam logic [15:0] ADDR_STAT = BASE_ADDRESS + 16'h000E;
   localparam logic [15:0] ADDR_DATA = BASE_ADDRESS + 16'h000A;

   localparam logic [CNT_WIDTH-1:0] HOLD_SAT   = CNT_WIDTH'(MIN_HOLD);
   localparam logic [CNT_WIDTH-1:0] HOLD_ARM   = CNT_WIDTH'(MIN_HOLD - 2);
   localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(READY_DELAY - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HELD     = 3'd1,
      ARMED    = 3'd2,
      INIT     = 3'd3,
      READY_AA = 3'd4,
      RUN      = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 hit_rst, hit_stat, hit_data;
   logic                 wr_one, wr_zero, rd_take;
   logic [CNT_WIDTH-1:0] cnt_sat_inc;

   assign hit_rst  = (address == ADDR_RST);
   assign hit_stat = (address == ADDR_STAT);
   assign hit_data = (address == ADDR_DATA);

   assign wr_one  = write_strobe & hit_rst & data_in[0];
   assign wr_zero = write_strobe & hit_rst & ~data_in[0];
   // A read that coincides with any write loses its side effect.
   assign rd_take = read_strobe & ~write_strobe & hit_data;

   assign cnt_sat_inc = (cnt_q < HOLD_SAT) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

   always_ff @(posedge bus_clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (wr_one) begin
               state_d = HELD;
               cnt_d   = '0;
            end
         end
         HELD: begin
            // Any release seen while still HELD is premature.
            if (wr_zero) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_sat_inc;
               if (cnt_q == HOLD_ARM) state_d = ARMED;
            end
         end
         ARMED: begin
            if (wr_zero) begin
               state_d = INIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_sat_inc;
            end
         end
         INIT: begin
            if (wr_one) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DELAY_LAST) begin
               state_d = READY_AA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         READY_AA: begin
            if (wr_one) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (rd_take) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (wr_one) begin
               state_d = HELD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Read path is combinational so the host sees data in the strobe cycle.
   always_comb begin
      data_out = 16'h0000;
      data_oe  = read_strobe & (hit_stat | hit_data);
      if (read_strobe && state_q == READY_AA) begin
         if (hit_stat) data_out = 16'h0080;
         if (hit_data) data_out = 16'h00AA;
      end
   end

   assign in_reset  = (state_q == HELD) || (state_q == ARMED);
   assign dsp_ready = (state_q == RUN);

endmodule

// File: doc/dsp_reset_responder.md
Name: dsp_reset_responder

Overview:
Card-side responder for the DSP reset handshake on the host I/O bus.
- Decodes host bus cycles to the reset, read-buffer-status and read-data ports.
- Enforces the minimum reset-hold time, then raises data-available after an init delay and returns the 0xAA ready byte.
- Sits in the riser's port-decode logic, serving the host's reset/probe sequence.

Parameters:
BASE_ADDRESS, 16'h0000, I/O base; ports are BASE+6 reset, BASE+E read-buffer status, BASE+A read data.
MIN_HOLD, 24, minimum bus_clock cycles the reset bit must stay 1 (3 us).
READY_DELAY, 16, cycles from accepted reset release to data-available.
CNT_WIDTH, 6, width of the shared hold/delay counter; must hold max(MIN_HOLD, READY_DELAY).

Ports:
- bus_clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- address  in  16  host bus address.
- data_in  in  16  host write data; only bit 0 is used for the reset port.
- write_strobe  in  1  one-cycle host write qualifier.
- read_strobe  in  1  one-cycle host read qualifier.
- data_out  out  16  read data, combinational from address and state.
- data_oe  out  1  high when read_strobe is high and address is E or A.
- in_reset  out  1  high in HELD or ARMED.
- dsp_ready  out  1  high in RUN.

Behaviour:
- Reset values: state IDLE, counter 0, data_out 0, data_oe 0, in_reset 0, dsp_ready 0. All values are forced on reset assertion without waiting for a clock edge.
- Read timing: zero-latency. data_out is valid in the same cycle as read_strobe. Read side effects take effect at the rising edge that samples read_strobe.
- Port E read: 16'h0080 in READY_AA, 16'h0000 in every other state.
- Port A read: 16'h00AA in READY_AA, 16'h0000 in every other state.
- Reads of other addresses: data_out 0, data_oe 0.
- Address hits are exact 16-bit compares. Writes to E or A are ignored.

States:
- IDLE: write 1 to port 6 -> HELD, counter cleared.
- HELD: counter +1 per cycle, saturating at MIN_HOLD.
  - The write-1 edge is edge 0.
  - A write 0 to port 6 sampled at edge n is accepted iff n >= MIN_HOLD.
    - Accepted -> INIT, counter cleared.
    - Otherwise -> IDLE (premature release; no ready byte).
  - At n = MIN_HOLD-1, with no write at that edge, -> ARMED.
- ARMED: write 0 -> INIT, counter cleared.
- HELD or ARMED: repeated write 1 is ignored; the hold is not restarted.
- INIT: counter +1 per cycle. At counter == READY_DELAY-1 -> READY_AA, so data-available is first visible READY_DELAY cycles after the release edge.
- READY_AA: read of port A -> RUN.
- Any state other than HELD or ARMED: write 1 to port 6 -> HELD, counter cleared. This includes INIT, READY_AA and RUN; a re-reset aborts any pending delay or byte.
- IDLE/INIT/READY_AA/RUN: write 0 to port 6 is ignored.
- Simultaneous write_strobe and read_strobe:
  - The write is processed.
  - The read still drives data_out from the pre-edge state.
  - The read side effect (READY_AA -> RUN) is suppressed.
- Undefined state encodings -> IDLE.

Test Plan:
- Normal sequence, BASE_ADDRESS=16'h0220:
  - Write 1 to 0x0226, 24 idle cycles, write 0 to 0x0226.
  - Poll 0x022E: 0x0000 for 16 cycles, then 0x0080.
  - Read 0x022A: 0x00AA.
  - Next 0x022E read: 0x0000; dsp_ready=1; in_reset=1 throughout the hold.
- Premature release: write 1, then write 0 at edge 23 -> IDLE. Port E stays 0x0000 for 100 cycles; dsp_ready=0.
- Hold boundary: write 0 at edge 24 -> accepted; 0x0080 appears 16 cycles later.
- Async reset asserted mid-INIT between clock edges -> in_reset/dsp_ready/data_out go 0 immediately. After release, port E reads 0x0000 indefinitely.
- Re-reset from RUN: write 1 -> in_reset=1, dsp_ready=0; full sequence repeats with 0xAA returned again. Repeated write 1 at edge 10 does not extend the hold; release at edge 24 is accepted.
- Decode and collision:
  - Writes to 0x0006 ignored with base 0x0220.
  - Simultaneous read of port A and write 1 to port 6 while in READY_AA -> data_out 0x00AA that cycle, next state HELD.
